// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and encodings for the PC sequencer.
// The pc_src encodings are also used by program_counter and anything that
// decodes its select input, so they live here rather than in the FSM.
package pc_seq_pkg;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_UPDATE = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   // How the next PC is chosen for a retired instruction
   typedef enum logic [1:0] {
      CLS_SEQ    = 2'd0,
      CLS_JUMP   = 2'd1,
      CLS_REG    = 2'd2,
      CLS_BRANCH = 2'd3
   } instr_class_t;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;

   // SPECIAL function codes (instr[5:0])
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;

   // program_counter source select
   localparam logic [1:0] PC_SRC_BRANCH = 2'b00;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
   localparam logic [1:0] PC_SRC_REG    = 2'b10;
   localparam logic [1:0] PC_SRC_SEQ    = 2'b11;

   // beq is taken on a zero ALU result, bne on a non-zero one
   function automatic logic branch_taken(input logic is_bne, input logic alu_zero);
      return is_bne ? !alu_zero : alu_zero;
   endfunction

endpackage

// File: rtl/pc_seq_decode.sv
// pc_seq_decode: combinational classification of a captured instruction
// into the PC update class, plus a flag selecting bne over beq polarity.
module pc_seq_decode
   import pc_seq_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output instr_class_t cls,
   output logic         is_bne
);

   // Map opcode/funct onto the PC update class; anything unlisted is sequential
   always_comb begin
      cls = CLS_SEQ;
      case (opcode)
         OP_J, OP_JAL:     cls = CLS_JUMP;
         OP_BEQ, OP_BNE:   cls = CLS_BRANCH;
         OP_SPECIAL: begin
            if ((funct == FN_JR) || (funct == FN_JALR)) begin
               cls = CLS_REG;
            end
         end
         default:          cls = CLS_SEQ;
      endcase
   end

   assign is_bne = (opcode == OP_BNE);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle PC sequencing FSM for the MIPS-subset core.
// Per instruction: fetch (req/ack), decode, wait for execute, then a single
// PC write with the pc_src select for that instruction.
// Optional fetch watchdog: define PC_SEQ_TIMEOUT_EN to fault (sticky trap)
// after MEM_TIMEOUT request cycles without an acknowledge.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int COUNT_W     = 32
)
(
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   input  logic               imem_ack,
   input  logic [31:0]        instr,
   output logic               ir_load,
   output logic               exec_start,
   input  logic               exec_done,
   input  logic               alu_zero,
   output logic [1:0]         pc_src,
   output logic               pc_en,
   output logic [COUNT_W-1:0] instr_count,
   output logic               trap
);

   state_t       state;
   state_t       next_state;

   logic [5:0]   opcode_q;
   logic [5:0]   funct_q;
   instr_class_t dec_cls;
   logic         dec_is_bne;
   instr_class_t cls_q;
   logic         taken_q;
   logic         exec_first_q;
   logic         timeout_hit;

   // Only the opcode and funct fields steer sequencing
   logic         unused_instr;
   assign unused_instr = ^instr[25:6];

   pc_seq_decode u_decode (
      .opcode (opcode_q),
      .funct  (funct_q),
      .cls    (dec_cls),
      .is_bne (dec_is_bne)
   );

`ifdef PC_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

   // wait_cnt holds how many request cycles have already gone unanswered;
   // it is zero on FETCH entry because it clears in every other state
   logic [WD_W-1:0] wait_cnt;

   // Count unanswered request cycles while fetching
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if ((state == ST_FETCH) && !imem_ack) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // The MEM_TIMEOUT-th request cycle without ack faults; an ack in that
   // same cycle still wins because the term requires !imem_ack
   assign timeout_hit = (state == ST_FETCH) && !imem_ack &&
                        (wait_cnt == WD_W'(MEM_TIMEOUT - 1));
`else
   // MEM_TIMEOUT only matters with the watchdog compiled in
   logic unused_timeout;
   assign unused_timeout = |MEM_TIMEOUT;
   assign timeout_hit    = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   next_state = ST_FETCH;
         ST_FETCH: begin
            if (imem_ack) begin
               next_state = ST_DECODE;
            end else if (timeout_hit) begin
               next_state = ST_FAULT;
            end
         end
         ST_DECODE: next_state = ST_EXEC;
         ST_EXEC: begin
            if (exec_done) begin
               next_state = ST_UPDATE;
            end
         end
         ST_UPDATE: next_state = ST_FETCH;
         ST_FAULT:  next_state = ST_FAULT;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Output decode from state and the per-instruction registers; ir_load is
   // the one term that follows imem_ack directly, since instr is only valid
   // in the ack cycle and the external IR must capture it then
   always_comb begin
      imem_req   = (state == ST_FETCH);
      ir_load    = (state == ST_FETCH) && imem_ack;
      exec_start = (state == ST_EXEC) && exec_first_q;
      pc_en      = (state == ST_UPDATE);
      pc_src     = PC_SRC_SEQ;
      if (state == ST_UPDATE) begin
         case (cls_q)
            CLS_JUMP:   pc_src = PC_SRC_JUMP;
            CLS_REG:    pc_src = PC_SRC_REG;
            CLS_BRANCH: pc_src = taken_q ? PC_SRC_BRANCH : PC_SRC_SEQ;
            default:    pc_src = PC_SRC_SEQ;
         endcase
      end
`ifdef PC_SEQ_TIMEOUT_EN
      trap = (state == ST_FAULT);
`else
      trap = 1'b0;
`endif
   end

   // Capture the fields that steer decode when the fetch completes
   always_ff @(posedge clk) begin
      if ((state == ST_FETCH) && imem_ack) begin
         opcode_q <= instr[31:26];
         funct_q  <= instr[5:0];
      end
   end

   // Latch the class in DECODE and the branch decision when execute finishes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls_q   <= CLS_SEQ;
         taken_q <= 1'b0;
      end else begin
         if (state == ST_DECODE) begin
            cls_q <= dec_cls;
         end
         if ((state == ST_EXEC) && exec_done) begin
            taken_q <= branch_taken(dec_is_bne, alu_zero);
         end
      end
   end

   // DECODE always leads to EXEC, so this marks the first EXEC cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_first_q <= 1'b0;
      end else begin
         exec_first_q <= (state == ST_DECODE);
      end
   end

   // Retired-instruction counter, bumped as the UPDATE cycle completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_count <= '0;
      end else if (state == ST_UPDATE) begin
         instr_count <= instr_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer. Inputs change on the
// falling edge; outputs are sampled 1 ns later, away from the rising edge.
// A 4-bit counter width is used so the wrap to zero is reached quickly.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam int MEM_TO = 15;
   localparam int CW     = 4;

   logic          clk;
   logic          rst_n;
   logic          imem_req;
   logic          imem_ack;
   logic [31:0]   instr;
   logic          ir_load;
   logic          exec_start;
   logic          exec_done;
   logic          alu_zero;
   logic [1:0]    pc_src;
   logic          pc_en;
   logic [CW-1:0] instr_count;
   logic          trap;

   int            n_checks = 0;
   int            n_err    = 0;
   logic [CW-1:0] exp_count = '0;

   pc_sequencer #(.MEM_TIMEOUT(MEM_TO), .COUNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .instr       (instr),
      .ir_load     (ir_load),
      .exec_start  (exec_start),
      .exec_done   (exec_done),
      .alu_zero    (alu_zero),
      .pc_src      (pc_src),
      .pc_en       (pc_en),
      .instr_count (instr_count),
      .trap        (trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_time_limit observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_b({tag, ".imem_req"},   imem_req,   1'b0);
      chk_b({tag, ".ir_load"},    ir_load,    1'b0);
      chk_b({tag, ".exec_start"}, exec_start, 1'b0);
      chk_b({tag, ".pc_en"},      pc_en,      1'b0);
      chk_v({tag, ".pc_src"},     32'(pc_src), 32'(PC_SRC_SEQ));
      chk_v({tag, ".count"},      32'(instr_count), 32'd0);
      chk_b({tag, ".trap"},       trap,       1'b0);
   endtask

   // Entered during a FETCH cycle (before its inputs are applied); returns
   // 1 ns into the FETCH cycle of the following instruction.
   task automatic run_instr(input string tag, input logic [31:0] word,
                            input int fwait, input int ewait,
                            input logic zero, input logic [1:0] exp_src);
      logic [CW-1:0] cnt0;
      cnt0 = exp_count;
      for (int i = 0; i < fwait; i++) begin
         imem_ack = 1'b0; instr = ~word; #1;
         chk_b({tag, ".fwait_req"},   imem_req, 1'b1);
         chk_b({tag, ".fwait_load"},  ir_load,  1'b0);
         chk_b({tag, ".fwait_pc_en"}, pc_en,    1'b0);
         @(negedge clk);
      end
      imem_ack = 1'b1; instr = word; #1;
      chk_b({tag, ".fetch_req"},  imem_req, 1'b1);
      chk_b({tag, ".fetch_load"}, ir_load,  1'b1);
      chk_b({tag, ".fetch_pc_en"}, pc_en,   1'b0);
      @(negedge clk);
      // DECODE: a stray ack and a changed instr bus must have no effect
      imem_ack = 1'b1; instr = ~word; #1;
      chk_b({tag, ".dec_req"},   imem_req,   1'b0);
      chk_b({tag, ".dec_load"},  ir_load,    1'b0);
      chk_b({tag, ".dec_start"}, exec_start, 1'b0);
      @(negedge clk);
      imem_ack = 1'b0;
      for (int i = 0; i < ewait; i++) begin
         exec_done = 1'b0; alu_zero = ~zero; #1;
         chk_b({tag, ".ewait_start"}, exec_start, (i == 0));
         chk_b({tag, ".ewait_pc_en"}, pc_en, 1'b0);
         chk_v({tag, ".ewait_src"}, 32'(pc_src), 32'(PC_SRC_SEQ));
         @(negedge clk);
      end
      exec_done = 1'b1; alu_zero = zero; #1;
      chk_b({tag, ".done_start"}, exec_start, (ewait == 0));
      chk_b({tag, ".done_pc_en"}, pc_en, 1'b0);
      @(negedge clk);
      // UPDATE: flip alu_zero so a late sample would pick the wrong target
      exec_done = 1'b0; alu_zero = ~zero; #1;
      chk_b({tag, ".upd_pc_en"}, pc_en, 1'b1);
      chk_v({tag, ".upd_src"},   32'(pc_src), 32'(exp_src));
      chk_v({tag, ".upd_count"}, 32'(instr_count), 32'(cnt0));
      chk_b({tag, ".upd_req"},   imem_req, 1'b0);
      exp_count = exp_count + 1'b1;
      @(negedge clk);
      #1;
      chk_b({tag, ".next_pc_en"}, pc_en, 1'b0);
      chk_v({tag, ".next_src"},   32'(pc_src), 32'(PC_SRC_SEQ));
      chk_b({tag, ".next_req"},   imem_req, 1'b1);
      chk_v({tag, ".next_count"}, 32'(instr_count), 32'(exp_count));
   endtask

   initial begin
      rst_n = 1'b1; imem_ack = 1'b0; instr = 32'h0;
      exec_done = 1'b0; alu_zero = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk); #1;
      chk_reset_vals("reset");
      @(negedge clk);
      // Release: one IDLE cycle, then FETCH
      rst_n = 1'b1; #1;
      chk_b("idle_req", imem_req, 1'b0);
      @(negedge clk);

      run_instr("addi",   32'h20080005, 0, 0, 1'b0, PC_SRC_SEQ);
      run_instr("beq_t",  32'h10000004, 0, 0, 1'b1, PC_SRC_BRANCH);
      run_instr("beq_nt", 32'h10000004, 0, 0, 1'b0, PC_SRC_SEQ);
      run_instr("bne_t",  32'h14000004, 0, 0, 1'b0, PC_SRC_BRANCH);
      run_instr("bne_nt", 32'h14000004, 0, 0, 1'b1, PC_SRC_SEQ);
      run_instr("j",      32'h0800000F, 0, 0, 1'b0, PC_SRC_JUMP);
      run_instr("jr",     32'h03E00008, 0, 0, 1'b0, PC_SRC_REG);
      run_instr("jal",    32'h0C000010, 0, 0, 1'b1, PC_SRC_JUMP);
      run_instr("jalr",   32'h03E0F809, 0, 0, 1'b1, PC_SRC_REG);
      run_instr("ackdly", 32'h20080005, 3, 0, 1'b0, PC_SRC_SEQ);
      run_instr("exdly",  32'h10000004, 0, 2, 1'b1, PC_SRC_BRANCH);
      run_instr("add",    32'h00851020, 0, 0, 1'b1, PC_SRC_SEQ);
      // Carry the 4-bit counter through its wrap to zero
      for (int k = 0; k < 6; k++) begin
         run_instr("wrap", 32'h20080005, 0, 1, 1'b0, PC_SRC_SEQ);
      end
      // Ack on the last request cycle before the watchdog limit still completes
      run_instr("ack_at_limit", 32'h0800000F, MEM_TO - 1, 0, 1'b0, PC_SRC_JUMP);

      // Reset while EXEC waits, with exec_done arriving in the reset cycle
      imem_ack = 1'b1; instr = 32'h20080005; #1;
      chk_b("rx.load", ir_load, 1'b1);
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      exec_done = 1'b0; #1;
      chk_b("rx.start", exec_start, 1'b1);
      chk_v("rx.count_before", 32'(instr_count), 32'(exp_count));
      @(negedge clk);
      exec_done = 1'b1; rst_n = 1'b0; #1;
      chk_reset_vals("rx_async");
      exp_count = '0;
      @(negedge clk);
      exec_done = 1'b0; rst_n = 1'b1; #1;
      chk_b("rx.idle_req", imem_req, 1'b0);
      chk_b("rx.idle_pc_en", pc_en, 1'b0);
      @(negedge clk); #1;
      chk_b("rx.fetch_req", imem_req, 1'b1);
      run_instr("after_rst", 32'h03E00008, 0, 0, 1'b0, PC_SRC_REG);

`ifdef PC_SEQ_TIMEOUT_EN
      // No ack: request for MEM_TIMEOUT cycles, then sticky trap
      imem_ack = 1'b0;
      for (int i = 0; i < MEM_TO; i++) begin
         chk_b("wd.req", imem_req, 1'b1);
         chk_b("wd.trap_early", trap, 1'b0);
         @(negedge clk); #1;
      end
      chk_b("wd.trap", trap, 1'b1);
      chk_b("wd.req_off", imem_req, 1'b0);
      imem_ack = 1'b1; exec_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk_b("wd.trap_held", trap, 1'b1);
         chk_b("wd.no_pc_en", pc_en, 1'b0);
         chk_b("wd.no_req", imem_req, 1'b0);
      end
      imem_ack = 1'b0; exec_done = 1'b0;
      rst_n = 1'b0; #1;
      chk_reset_vals("wd_rst");
      exp_count = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_instr("after_trap", 32'h14000004, 0, 0, 1'b0, PC_SRC_BRANCH);
`else
      // Without the watchdog FETCH waits indefinitely and trap stays low
      imem_ack = 1'b0;
      for (int i = 0; i < MEM_TO + 5; i++) begin
         @(negedge clk); #1;
      end
      chk_b("nowd.req", imem_req, 1'b1);
      chk_b("nowd.trap", trap, 1'b0);
      run_instr("nowd_late", 32'h14000004, 0, 0, 1'b0, PC_SRC_BRANCH);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
